// File: rtl/demux_edge_counter_2ch.sv
// Two-channel rising-edge counter on a 1-to-2 demux output, with saturating live
// counters and an IDLE/HOLD snapshot handshake that presents stable counts to a consumer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no snapshot outstanding; snap_req captures live counts
//   ST_HOLD | snapshot presented on cnt0/cnt1; waiting for snap_ack
module demux_edge_counter_2ch #(
  parameter int unsigned CNT_W       = 8,
  parameter bit          CLR_ON_SNAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       demux_out,
  input  logic             clear,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             snap_valid,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [1:0]       sat
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic                   snap_valid_q;
  logic [CNT_W-1:0]       cnt0_q;
  logic [CNT_W-1:0]       cnt1_q;

  logic [1:0]             prev_q;
  logic [1:0][CNT_W-1:0]  live_q;
  logic [1:0][CNT_W-1:0]  live_d;
  logic [1:0]             sat_q;
  logic [1:0]             sat_d;

  logic [1:0]             rise;
  logic                   snap_fire;

  assign rise      = demux_out & ~prev_q;
  assign snap_fire = (state_q == ST_IDLE) && snap_req;

  // Priority: clear discards everything, then the snapshot reload, then normal counting.
  always_comb begin
    live_d = live_q;
    sat_d  = sat_q;
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        live_d[i] = CNT_ZERO;
        sat_d[i]  = 1'b0;
      end else if (snap_fire && CLR_ON_SNAP) begin
        live_d[i] = rise[i] ? CNT_ONE : CNT_ZERO;
      end else if (rise[i]) begin
        if (live_q[i] == CNT_MAX) begin
          sat_d[i] = 1'b1;
        end else begin
          live_d[i] = live_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b00;
      live_q <= '0;
      sat_q  <= 2'b00;
    end else begin
      prev_q <= demux_out;
      live_q <= live_d;
      sat_q  <= sat_d;
    end
  end

  // Snapshot captures the pre-update live values, so a same-cycle clear or edge is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      snap_valid_q <= 1'b0;
      cnt0_q       <= CNT_ZERO;
      cnt1_q       <= CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (snap_req) begin
            cnt0_q       <= live_q[0];
            cnt1_q       <= live_q[1];
            snap_valid_q <= 1'b1;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (snap_ack) begin
            snap_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          snap_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign snap_valid = snap_valid_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_demux_edge_counter_2ch.sv
// Bench for demux_edge_counter_2ch: two instances (4-bit clear-on-snap, 8-bit free-running)
// share one stimulus stream and are compared every cycle against a count-based model.
module tb_demux_edge_counter_2ch;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic [1:0] demux_out;
  logic       clear;
  logic       snap_req;
  logic       snap_ack;

  logic       valid_a, valid_b;
  logic [3:0] cnt0_a, cnt1_a;
  logic [7:0] cnt0_b, cnt1_b;
  logic [1:0] sat_a, sat_b;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: index 0 is instance a, index 1 is instance b.
  int  m_live [2][2];
  bit  m_sat  [2][2];
  int  m_cnt  [2][2];
  bit  m_hold [2];
  bit  m_valid[2];
  bit  m_prev [2];
  int  m_max  [2] = '{15, 255};
  bit  m_clros[2] = '{1'b1, 1'b0};

  demux_edge_counter_2ch #(.CNT_W(4), .CLR_ON_SNAP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .demux_out(demux_out), .clear(clear),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(valid_a),
    .cnt0(cnt0_a), .cnt1(cnt1_a), .sat(sat_a)
  );

  demux_edge_counter_2ch #(.CNT_W(8), .CLR_ON_SNAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .demux_out(demux_out), .clear(clear),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(valid_b),
    .cnt0(cnt0_b), .cnt1(cnt1_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k]  = 1'b0;
      m_valid[k] = 1'b0;
      m_prev[k]  = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_live[k][c] = 0;
        m_sat[k][c]  = 1'b0;
        m_cnt[k][c]  = 0;
      end
    end
  endtask

  task automatic model_step(input logic [1:0] d, input logic clr, input logic sr, input logic sa);
    bit fire;
    bit rise;
    for (int k = 0; k < 2; k++) begin
      fire = !m_hold[k] && sr;
      if (fire) begin
        m_cnt[k][0] = m_live[k][0];
        m_cnt[k][1] = m_live[k][1];
        m_valid[k]  = 1'b1;
        m_hold[k]   = 1'b1;
      end else if (m_hold[k] && sa) begin
        m_valid[k] = 1'b0;
        m_hold[k]  = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        rise = d[c] && !m_prev[c];
        if (clr) begin
          m_live[k][c] = 0;
          m_sat[k][c]  = 1'b0;
        end else if (fire && m_clros[k]) begin
          m_live[k][c] = rise ? 1 : 0;
        end else if (rise) begin
          if (m_live[k][c] >= m_max[k]) m_sat[k][c] = 1'b1;
          else m_live[k][c] = m_live[k][c] + 1;
        end
      end
    end
    m_prev[0] = d[0];
    m_prev[1] = d[1];
  endtask

  task automatic check_all(input string tag);
    check_val({tag, " a.valid"}, 32'(valid_a), 32'(m_valid[0]));
    check_val({tag, " a.cnt0"},  32'(cnt0_a),  m_cnt[0][0]);
    check_val({tag, " a.cnt1"},  32'(cnt1_a),  m_cnt[0][1]);
    check_val({tag, " a.sat"},   32'(sat_a),   {30'b0, m_sat[0][1], m_sat[0][0]});
    check_val({tag, " b.valid"}, 32'(valid_b), 32'(m_valid[1]));
    check_val({tag, " b.cnt0"},  32'(cnt0_b),  m_cnt[1][0]);
    check_val({tag, " b.cnt1"},  32'(cnt1_b),  m_cnt[1][1]);
    check_val({tag, " b.sat"},   32'(sat_b),   {30'b0, m_sat[1][1], m_sat[1][0]});
  endtask

  task automatic tick(input string tag, input logic [1:0] d, input logic clr,
                      input logic sr, input logic sa);
    demux_out = d;
    clear     = clr;
    snap_req  = sr;
    snap_ack  = sa;
    @(posedge clk);
    model_step(d, clr, sr, sa);
    #1;
    check_all(tag);
  endtask

  task automatic pulses(input string tag, input int n0, input int n1);
    for (int i = 0; i < ((n0 > n1) ? n0 : n1); i++) begin
      tick(tag, {logic'(i < n1), logic'(i < n0)}, 1'b0, 1'b0, 1'b0);
      tick(tag, 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    clk_run   = 1'b1;
    rst_n     = 1'b0;
    demux_out = 2'b00;
    clear     = 1'b0;
    snap_req  = 1'b0;
    snap_ack  = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_all("reset_rel");

    // First edge after reset with input high counts once.
    tick("first", 2'b01, 1'b0, 1'b0, 1'b0);
    tick("first", 2'b00, 1'b0, 1'b1, 1'b0);
    check_val("first a.cnt0", 32'(cnt0_a), 1);
    tick("first", 2'b00, 1'b0, 1'b0, 1'b1);

    // Five pulses on ch0, three on ch1.
    pulses("p53", 5, 3);
    tick("p53", 2'b00, 1'b0, 1'b1, 1'b0);
    check_val("p53 a.valid", 32'(valid_a), 1);
    check_val("p53 a.cnt0",  32'(cnt0_a), 5);
    check_val("p53 a.cnt1",  32'(cnt1_a), 3);
    tick("p53", 2'b00, 1'b0, 1'b0, 1'b1);
    check_val("p53 ack", 32'(valid_a), 0);

    // Level held high counts once per channel.
    repeat (10) tick("lvl", 2'b11, 1'b0, 1'b0, 1'b0);
    tick("lvl", 2'b11, 1'b0, 1'b1, 1'b0);
    check_val("lvl a.cnt0", 32'(cnt0_a), 1);
    check_val("lvl a.cnt1", 32'(cnt1_a), 1);
    tick("lvl", 2'b00, 1'b0, 1'b0, 1'b1);

    // Saturation on the 4-bit instance, then clear leaves the snapshot alone.
    pulses("sat", 20, 0);
    tick("sat", 2'b00, 1'b0, 1'b1, 1'b0);
    check_val("sat a.cnt0", 32'(cnt0_a), 15);
    check_val("sat a.sat",  32'(sat_a), 1);
    tick("sat", 2'b00, 1'b1, 1'b0, 1'b0);
    check_val("clr a.sat",  32'(sat_a), 0);
    check_val("clr a.cnt0", 32'(cnt0_a), 15);
    tick("sat", 2'b00, 1'b0, 1'b0, 1'b1);

    // Snapshot held without ack while pulses and extra requests continue.
    pulses("hold", 0, 2);
    tick("hold", 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick("hold", {1'b0, logic'(i % 2 == 0)}, 1'b0, 1'b1, 1'b0);
      check_val("hold a.valid", 32'(valid_a), 1);
      check_val("hold a.cnt1",  32'(cnt1_a), 2);
    end
    tick("hold", 2'b00, 1'b0, 1'b0, 1'b1);
    check_val("hold ack", 32'(valid_a), 0);
    tick("hold", 2'b00, 1'b0, 1'b1, 1'b0);
    check_val("hold2 a.cnt0", 32'(cnt0_a), 3);
    check_val("hold2 a.cnt1", 32'(cnt1_a), 0);
    tick("hold", 2'b00, 1'b0, 1'b0, 1'b1);
    tick("hold", 2'b00, 1'b0, 1'b0, 1'b1);

    // Clear and snapshot in the same cycle.
    pulses("cs", 7, 0);
    tick("cs", 2'b01, 1'b1, 1'b1, 1'b0);
    check_val("cs a.cnt0", 32'(cnt0_a), 7);
    tick("cs", 2'b00, 1'b0, 1'b0, 1'b1);
    tick("cs", 2'b00, 1'b0, 1'b1, 1'b0);
    check_val("cs after a.cnt0", 32'(cnt0_a), 0);
    tick("cs", 2'b00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in HOLD with the clock stopped.
    pulses("arst", 4, 2);
    tick("arst", 2'b11, 1'b0, 1'b1, 1'b0);
    clk_run = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("arst a.valid", 32'(valid_a), 0);
    check_val("arst a.cnt0",  32'(cnt0_a), 0);
    check_val("arst b.cnt1",  32'(cnt1_b), 0);
    check_all("arst");
    #3;
    demux_out = 2'b00;
    snap_req  = 1'b0;
    snap_ack  = 1'b1;
    rst_n     = 1'b1;
    clk_run   = 1'b1;
    tick("arst_rel", 2'b00, 1'b0, 1'b0, 1'b1);
    check_val("arst no pending", 32'(valid_a), 0);

    // Random traffic: busy handshakes, then long quiet stretches that reach saturation.
    for (int i = 0; i < 3000; i++)
      tick("rnd", 2'($urandom_range(0, 3)), logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0));
    for (int i = 0; i < 3000; i++)
      tick("rndq", 2'($urandom_range(0, 3)), logic'($urandom_range(0, 199) == 0),
           logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 2) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
